// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - shared state type, RGB332 layout and plane-bit decode for hub75_scanout
package hub75_pkg;

  typedef enum logic [2:0] {IDLE, SHIFT, LATCH, SHOW, NEXT} state_t;

  localparam int HUB75_COLS = 32;
  localparam int SCAN_LINES = 16;

  localparam int R_MSB = 7;
  localparam int R_LSB = 5;
  localparam int G_MSB = 4;
  localparam int G_LSB = 2;
  localparam int B_MSB = 1;
  localparam int B_LSB = 0;

  // Blue has only two stored bits; its MSB is replicated into bit 0 to fill three planes.
  function automatic logic [2:0] plane_bits(input logic [7:0] d, input logic [1:0] p);
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
    r = d[R_MSB:R_LSB];
    g = d[G_MSB:G_LSB];
    b = {d[B_MSB:B_LSB], d[B_MSB]};
    return {r[p], g[p], b[p]};
  endfunction

endpackage

// File: rtl/hub75_scanout_if.sv
// rtl/hub75_scanout_if.sv - framebuffer read-port bundle between scanout and RAM
interface hub75_scanout_if #(
  parameter int ADDR_WIDTH = 10
) ();
  logic [ADDR_WIDTH-1:0] ram_read_addr;
  logic                  ram_read_en;
  logic [7:0]            ram_read_data;

  modport master (
    output ram_read_addr,
    output ram_read_en,
    input  ram_read_data
  );

  modport slave (
    input  ram_read_addr,
    input  ram_read_en,
    output ram_read_data
  );
endinterface

// File: rtl/hub75_column_fetch.sv
// rtl/hub75_column_fetch.sv - 4-phase column sequencer fetching the top/bottom pixel pair
module hub75_column_fetch #(
  parameter int COLS       = 32,
  parameter int ROWS       = 32,
  parameter int ADDR_WIDTH = 10,
  localparam int ROW_W     = $clog2(ROWS / 2),
  localparam int COL_W     = $clog2(COLS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_active,
  input  logic [ROW_W-1:0]       i_row,
  hub75_scanout_if.master        ram,
  output logic [7:0]             o_top,
  output logic [7:0]             o_bot,
  output logic [1:0]             o_phase,
  output logic                   o_last
);

  logic [1:0]       r_phase;
  logic [COL_W-1:0] r_col;
  logic [7:0]       r_top;
  logic [7:0]       r_bot;
  logic             w_half;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_phase <= '0;
      r_col   <= '0;
      r_top   <= '0;
      r_bot   <= '0;
    end else if (i_active) begin
      r_phase <= r_phase + 2'd1;
      if (r_phase == 2'd3) r_col <= r_col + 1'b1;
      if (r_phase == 2'd1) r_top <= ram.ram_read_data;
      if (r_phase == 2'd2) r_bot <= ram.ram_read_data;
    end else begin
      r_phase <= '0;
      r_col   <= '0;
    end
  end

  // Bottom half of the panel sits at the upper half of the address space.
  assign w_half            = (r_phase == 2'd1);
  assign ram.ram_read_en   = i_active;
  assign ram.ram_read_addr = i_active ? ADDR_WIDTH'({w_half, i_row, r_col}) : '0;

  // Bottom byte is forwarded straight from the RAM in ph2 so colours settle a full cycle before the clock rise.
  assign o_top   = r_top;
  assign o_bot   = (r_phase == 2'd2) ? ram.ram_read_data : r_bot;
  assign o_phase = r_phase;
  assign o_last  = i_active && (r_phase == 2'd3) && (r_col == COL_W'(COLS - 1));

endmodule

// File: rtl/hub75_scanout.sv
// rtl/hub75_scanout.sv - framebuffer-to-HUB75 scanout with 3-plane binary-coded modulation
// Optional HUB75_BRIGHTNESS_EN adds a 4-bit brightness input gating output-enable during SHOW.
module hub75_scanout
  import hub75_pkg::*;
#(
  parameter int COLS         = HUB75_COLS,
  parameter int ROWS         = 2 * SCAN_LINES,
  parameter int PLANES       = 3,
  parameter int BASE_ON_TIME = 16,
  parameter int ADDR_WIDTH   = 10,
  localparam int ROW_W       = $clog2(ROWS / 2)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
`ifdef HUB75_BRIGHTNESS_EN
  input  logic [3:0]       brightness,
`endif
  hub75_scanout_if.master  ram,
  output logic             hub75_r1,
  output logic             hub75_g1,
  output logic             hub75_b1,
  output logic             hub75_r2,
  output logic             hub75_g2,
  output logic             hub75_b2,
  output logic             hub75_clk,
  output logic             hub75_lat,
  output logic             hub75_oe_n,
  output logic [ROW_W-1:0] hub75_addr,
  output logic             frame_done
);

  localparam int SHOW_W = $clog2(BASE_ON_TIME << (PLANES - 1)) + 1;
  localparam logic [SHOW_W-1:0] LP_BASE = SHOW_W'(BASE_ON_TIME);

  state_t            r_state;
  state_t            w_next;
  logic [ROW_W-1:0]  r_row;
  logic [1:0]        r_plane;
  logic [SHOW_W-1:0] r_show_cnt;
  logic [ROW_W-1:0]  r_hub75_addr;

  logic [7:0]        w_top;
  logic [7:0]        w_bot;
  logic [1:0]        w_phase;
  logic              w_shift_last;
  logic              w_show_last;
  logic              w_plane_last;
  logic              w_row_last;
  logic              w_oe_on;
  logic [2:0]        w_rgb1;
  logic [2:0]        w_rgb2;

  hub75_column_fetch #(
    .COLS       (COLS),
    .ROWS       (ROWS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fetch (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_active (r_state == SHIFT),
    .i_row    (r_row),
    .ram      (ram),
    .o_top    (w_top),
    .o_bot    (w_bot),
    .o_phase  (w_phase),
    .o_last   (w_shift_last)
  );

  assign w_show_last  = (r_show_cnt == (LP_BASE << r_plane) - 1'b1);
  assign w_plane_last = (r_plane == 2'(PLANES - 1));
  assign w_row_last   = (r_row == ROW_W'(ROWS / 2 - 1));

`ifdef HUB75_BRIGHTNESS_EN
  logic [3:0] r_bright;

  always_ff @(posedge clk) begin
    if (!reset_n) r_bright <= '0;
    else if (r_state == LATCH) r_bright <= brightness;
  end

  assign w_oe_on = (r_show_cnt[3:0] < r_bright);
`else
  assign w_oe_on = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_row        <= '0;
      r_plane      <= '0;
      r_show_cnt   <= '0;
      r_hub75_addr <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == SHIFT && w_shift_last) r_hub75_addr <= r_row;
      if (r_state == LATCH) r_show_cnt <= '0;
      else if (r_state == SHOW) r_show_cnt <= r_show_cnt + 1'b1;
      if (r_state == NEXT) begin
        if (w_plane_last) begin
          r_plane <= '0;
          r_row   <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_plane <= r_plane + 2'd1;
        end
      end
    end
  end

  // Enable is only looked at in IDLE, so a frame in flight always runs to completion.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (enable) w_next = SHIFT;
      SHIFT:   if (w_shift_last) w_next = LATCH;
      LATCH:   w_next = SHOW;
      SHOW:    if (w_show_last) w_next = NEXT;
      NEXT:    w_next = (w_plane_last && w_row_last) ? IDLE : SHIFT;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    hub75_clk  = 1'b0;
    hub75_lat  = 1'b0;
    hub75_oe_n = 1'b1;
    frame_done = 1'b0;
    if (r_state == SHIFT && w_phase == 2'd3) hub75_clk = 1'b1;
    if (r_state == LATCH) hub75_lat = 1'b1;
    if (r_state == SHOW && w_oe_on) hub75_oe_n = 1'b0;
    if (r_state == NEXT && w_plane_last && w_row_last) frame_done = 1'b1;
  end

  assign w_rgb1 = plane_bits(w_top, r_plane);
  assign w_rgb2 = plane_bits(w_bot, r_plane);
  assign {hub75_r1, hub75_g1, hub75_b1} = w_rgb1;
  assign {hub75_r2, hub75_g2, hub75_b2} = w_rgb2;
  assign hub75_addr = r_hub75_addr;

endmodule
